// File: rtl/adder_part_sched.sv
// Round-robin scheduler sharing one approximate adder slice among NREQ requesters.
// Optional error monitor enabled by defining ADDER_ERRMON_EN.
module adder_part_sched #(
    parameter int NREQ  = 4,
    parameter int IN_W  = 11,
    parameter int OUT_W = 7,
    parameter int IDW   = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req_valid,
    input  logic [NREQ*IN_W-1:0] req_data,
    output logic [NREQ-1:0]      req_ready,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [OUT_W-1:0]     rsp_data,
    output logic [IDW-1:0]       rsp_id,
    output logic [IN_W-1:0]      dp_in,
    input  logic [OUT_W-1:0]     dp_out,
`ifdef ADDER_ERRMON_EN
    input  logic                 err_clr,
    output logic [15:0]          err_cnt,
    output logic [OUT_W-1:0]     err_max,
`endif
    output logic                 busy
);

    localparam int OPW = (IN_W - 1) / 2;

    logic             s1_v_q, s1_v_d;
    logic             s2_v_q, s2_v_d;
    logic [IDW-1:0]   rr_ptr_q, rr_ptr_d;
    logic [IN_W-1:0]  dp_in_q, dp_in_d;
    logic [IDW-1:0]   id1_q, id1_d;
    logic [OUT_W-1:0] rsp_data_q, rsp_data_d;
    logic [IDW-1:0]   rsp_id_q, rsp_id_d;

    logic             adv1, adv2;
    logic             win_found;
    logic [IDW-1:0]   win_id;
    logic             accept;

    assign adv2 = ~s2_v_q | rsp_ready;
    assign adv1 = ~s1_v_q | adv2;

    // Scan from rr_ptr upward, wrapping at NREQ
    always_comb begin
        win_found = 1'b0;
        win_id    = '0;
        for (int k = 0; k < NREQ; k++) begin
            int idx;
            idx = int'(rr_ptr_q) + k;
            if (idx >= NREQ) idx = idx - NREQ;
            if (!win_found && req_valid[idx]) begin
                win_found = 1'b1;
                win_id    = IDW'(idx);
            end
        end
    end

    assign accept = win_found & adv1 & ~rst;

    always_comb begin
        req_ready = '0;
        if (accept) req_ready[win_id] = 1'b1;
    end

    always_comb begin
        s1_v_d     = s1_v_q;
        s2_v_d     = s2_v_q;
        rr_ptr_d   = rr_ptr_q;
        dp_in_d    = dp_in_q;
        id1_d      = id1_q;
        rsp_data_d = rsp_data_q;
        rsp_id_d   = rsp_id_q;
        if (accept) begin
            dp_in_d  = req_data[win_id*IN_W +: IN_W];
            id1_d    = win_id;
            s1_v_d   = 1'b1;
            rr_ptr_d = (win_id == IDW'(NREQ - 1)) ? '0 : win_id + 1'b1;
        end else if (adv1) begin
            s1_v_d = 1'b0;
        end
        if (adv2) begin
            s2_v_d = s1_v_q;
            if (s1_v_q) begin
                rsp_data_d = dp_out;
                rsp_id_d   = id1_q;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_v_q     <= 1'b0;
            s2_v_q     <= 1'b0;
            rr_ptr_q   <= '0;
            dp_in_q    <= '0;
            id1_q      <= '0;
            rsp_data_q <= '0;
            rsp_id_q   <= '0;
        end else begin
            s1_v_q     <= s1_v_d;
            s2_v_q     <= s2_v_d;
            rr_ptr_q   <= rr_ptr_d;
            dp_in_q    <= dp_in_d;
            id1_q      <= id1_d;
            rsp_data_q <= rsp_data_d;
            rsp_id_q   <= rsp_id_d;
        end
    end

    assign rsp_valid = s2_v_q;
    assign rsp_data  = rsp_data_q;
    assign rsp_id    = rsp_id_q;
    assign dp_in     = dp_in_q;
    assign busy      = s1_v_q | s2_v_q;

`ifdef ADDER_ERRMON_EN
    logic [15:0]      err_cnt_q, err_cnt_d;
    logic [OUT_W-1:0] err_max_q, err_max_d;
    logic [OPW:0]     sum;
    logic [OUT_W-1:0] exact;
    logic [OUT_W-1:0] diff;

    // Reference sum of the operands currently driving the slice
    always_comb begin
        sum   = {1'b0, dp_in_q[2*OPW -: OPW]} + {1'b0, dp_in_q[OPW -: OPW]}
              + {{OPW{1'b0}}, dp_in_q[0]};
        exact = OUT_W'(sum);
        diff  = (dp_out >= exact) ? dp_out - exact : exact - dp_out;
    end

    always_comb begin
        err_cnt_d = err_cnt_q;
        err_max_d = err_max_q;
        if (err_clr) begin
            err_cnt_d = '0;
            err_max_d = '0;
        end else if (adv2 && s1_v_q && dp_out != exact) begin
            if (err_cnt_q != 16'hFFFF) err_cnt_d = err_cnt_q + 16'd1;
            if (diff > err_max_q) err_max_d = diff;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            err_cnt_q <= '0;
            err_max_q <= '0;
        end else begin
            err_cnt_q <= err_cnt_d;
            err_max_q <= err_max_d;
        end
    end

    assign err_cnt = err_cnt_q;
    assign err_max = err_max_q;
`endif

endmodule

// File: tb/tb_adder_part_sched.sv
// Scoreboard bench for adder_part_sched with a behavioural approximate slice.
// Error-monitor checks run when ADDER_ERRMON_EN is defined.
module tb_adder_part_sched;

    localparam int NREQ  = 4;
    localparam int IN_W  = 11;
    localparam int OUT_W = 7;
    localparam int IDW   = 2;

    logic                 clk = 1'b0;
    logic                 rst;
    logic [NREQ-1:0]      req_valid;
    logic [NREQ*IN_W-1:0] req_data;
    logic [NREQ-1:0]      req_ready;
    logic                 rsp_valid;
    logic                 rsp_ready;
    logic [OUT_W-1:0]     rsp_data;
    logic [IDW-1:0]       rsp_id;
    logic [IN_W-1:0]      dp_in;
    logic [OUT_W-1:0]     dp_out;
    logic                 busy;
`ifdef ADDER_ERRMON_EN
    logic                 err_clr;
    logic [15:0]          err_cnt;
    logic [OUT_W-1:0]     err_max;
`endif

    always #5 clk = ~clk;

    adder_part_sched #(.NREQ(NREQ), .IN_W(IN_W), .OUT_W(OUT_W), .IDW(IDW)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_data(rsp_data), .rsp_id(rsp_id),
        .dp_in(dp_in), .dp_out(dp_out),
`ifdef ADDER_ERRMON_EN
        .err_clr(err_clr), .err_cnt(err_cnt), .err_max(err_max),
`endif
        .busy(busy)
    );

    int n_vec = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Approximate slice: low bit is an OR, upper bits ignore the bit-0 carry
    function automatic logic [6:0] approx(input logic [10:0] d);
        logic [4:0] hi;
        hi = {1'b0, d[9:7]} + {1'b0, d[4:2]};
        hi = {1'b0, d[10:7]} + {1'b0, d[5:2]};
        return {1'b0, hi, d[6] | d[1] | d[0]};
    endfunction

    function automatic logic [10:0] bnd(input int a, input int b, input int c);
        logic [4:0] av, bv;
        logic       cv;
        av = a[4:0];
        bv = b[4:0];
        cv = c[0];
        return {av, bv, cv};
    endfunction

    logic             force_en = 1'b0;
    logic [OUT_W-1:0] force_val = '0;
    logic             keep_data = 1'b0;
    assign dp_out = force_en ? force_val : approx(dp_in);

    typedef struct packed {
        logic [IDW-1:0]   id;
        logic [OUT_W-1:0] data;
    } exp_t;

    exp_t             sb[$];
    int               tb_rr = 0;
    logic [NREQ-1:0]  acc_mask = '0;
    int               cnt[NREQ];
    int               n_acc = 0;
    int               n_rsp = 0;
    int               cyc = 0;
    int               first_rsp = -1;
    int               last_rsp = -1;
    logic             held_v = 1'b0;
    logic [OUT_W-1:0] held_data;
    logic [IDW-1:0]   held_id;

    always @(negedge clk) begin
        cyc++;
        acc_mask = '0;
        if (rst) begin
            sb.delete();
            tb_rr  = 0;
            held_v = 1'b0;
        end else begin
            if (req_ready != '0) begin
                int w;
                int acc;
                logic [NREQ-1:0] oh;
                w = -1;
                for (int k = 0; k < NREQ; k++) begin
                    int ix;
                    ix = (tb_rr + k) % NREQ;
                    if (w < 0 && req_valid[ix]) w = ix;
                end
                oh = '0;
                if (w >= 0) oh[w] = 1'b1;
                chk("grant", 32'(req_ready), 32'(oh));
                acc = -1;
                for (int k = 0; k < NREQ; k++)
                    if (req_ready[k] && req_valid[k]) acc = k;
                if (acc >= 0) begin
                    exp_t e;
                    e.id   = IDW'(acc);
                    e.data = force_en ? force_val : approx(req_data[acc*IN_W +: IN_W]);
                    sb.push_back(e);
                    acc_mask[acc] = 1'b1;
                    n_acc++;
                    tb_rr = (acc + 1) % NREQ;
                end
            end
            if (held_v) begin
                chk("hold_valid", 32'(rsp_valid), 32'd1);
                chk("hold_data", 32'(rsp_data), 32'(held_data));
                chk("hold_id", 32'(rsp_id), 32'(held_id));
            end
            if (rsp_valid && rsp_ready) begin
                chk("rsp_expected", 32'(sb.size() != 0), 32'd1);
                if (sb.size() != 0) begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("rsp_id", 32'(rsp_id), 32'(e.id));
                    chk("rsp_data", 32'(rsp_data), 32'(e.data));
                end
                n_rsp++;
                if (first_rsp < 0) first_rsp = cyc;
                last_rsp = cyc;
            end
            held_v    = rsp_valid & ~rsp_ready;
            held_data = rsp_data;
            held_id   = rsp_id;
        end
    end

    // Requesters: reload a new bundle while count remains, else drop valid
    initial begin
        forever begin
            @(posedge clk);
            #1;
            for (int i = 0; i < NREQ; i++) begin
                if (acc_mask[i]) begin
                    if (cnt[i] > 0) begin
                        cnt[i]--;
                        if (!keep_data) req_data[i*IN_W +: IN_W] = IN_W'($urandom);
                    end else begin
                        req_valid[i] = 1'b0;
                    end
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic wait_idle(input int bound);
        int k;
        k = 0;
        while ((busy || req_valid != '0 || sb.size() != 0) && k < bound) begin
            tick(1);
            k++;
        end
        chk("drain_q", 32'(sb.size()), 32'd0);
        chk("drain_busy", 32'(busy), 32'd0);
    endtask

    int a0, r0;
    logic [IN_W-1:0] b1;

    initial begin
        for (int i = 0; i < NREQ; i++) cnt[i] = 0;
        rst       = 1'b1;
        req_valid = '0;
        req_data  = '0;
        rsp_ready = 1'b1;
`ifdef ADDER_ERRMON_EN
        err_clr = 1'b0;
`endif
        tick(3);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_req_ready", 32'(req_ready), 32'd0);
        chk("rst_dp_in", 32'(dp_in), 32'd0);
        chk("rst_rsp_data", 32'(rsp_data), 32'd0);
        chk("rst_rsp_id", 32'(rsp_id), 32'd0);
        rst = 1'b0;
        tick(1);

        // single request
        b1 = bnd(3, 4, 1);
        req_data[1*IN_W +: IN_W] = b1;
        req_valid = 4'b0010;
        @(negedge clk);
        chk("t1_ready", 32'(req_ready), 32'b0010);
        @(negedge clk);
        chk("t1_dp_in", 32'(dp_in), 32'(b1));
        chk("t1_rsp_early", 32'(rsp_valid), 32'd0);
        chk("t1_ready_off", 32'(req_ready), 32'd0);
        @(negedge clk);
        chk("t1_rsp_valid", 32'(rsp_valid), 32'd1);
        chk("t1_rsp_id", 32'(rsp_id), 32'd1);
        chk("t1_rsp_data", 32'(rsp_data), 32'(approx(b1)));
        tick(1);
        wait_idle(50);

        // fairness and full throughput
        for (int i = 0; i < NREQ; i++) begin
            req_data[i*IN_W +: IN_W] = IN_W'($urandom);
            cnt[i] = 3;
        end
        a0 = n_acc; r0 = n_rsp; first_rsp = -1;
        req_valid = 4'b1111;
        wait_idle(100);
        chk("t2_accepts", 32'(n_acc - a0), 32'd16);
        chk("t2_rsps", 32'(n_rsp - r0), 32'd16);
        chk("t2_span", 32'(last_rsp - first_rsp), 32'd15);

        // backpressure
        rsp_ready = 1'b0;
        for (int i = 0; i < NREQ; i++) req_data[i*IN_W +: IN_W] = IN_W'($urandom);
        a0 = n_acc; r0 = n_rsp;
        req_valid = 4'b1111;
        tick(5);
        chk("t3_accepts", 32'(n_acc - a0), 32'd2);
        chk("t3_ready", 32'(req_ready), 32'd0);
        chk("t3_rsp_valid", 32'(rsp_valid), 32'd1);
        rsp_ready = 1'b1;
        wait_idle(100);
        chk("t3_rsps", 32'(n_rsp - r0), 32'd4);

        // reset mid-flight
        rsp_ready = 1'b0;
        req_valid = 4'b0011;
        tick(3);
        chk("t4_busy_pre", 32'(busy), 32'd1);
        chk("t4_rsp_pre", 32'(rsp_valid), 32'd1);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        chk("t4_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("t4_busy", 32'(busy), 32'd0);
        req_valid = 4'b0110;
        rsp_ready = 1'b1;
        @(negedge clk);
        chk("t4_grant", 32'(req_ready), 32'b0010);
        tick(1);
        wait_idle(50);

`ifdef ADDER_ERRMON_EN
        err_clr = 1'b1;
        tick(1);
        err_clr = 1'b0;
        force_en  = 1'b1;
        force_val = 7'd60;
        req_data[0 +: IN_W] = bnd(31, 31, 1);
        req_valid = 4'b0001;
        wait_idle(50);
        chk("t5_cnt", 32'(err_cnt), 32'd1);
        chk("t5_max", 32'(err_max), 32'd3);
        force_en = 1'b0;
        req_data[0 +: IN_W] = bnd(2, 4, 0);
        req_valid = 4'b0001;
        wait_idle(50);
        chk("t5_cnt_hold", 32'(err_cnt), 32'd1);
        chk("t5_max_hold", 32'(err_max), 32'd3);
        err_clr = 1'b1;
        tick(1);
        err_clr = 1'b0;
        chk("t5_cnt_clr", 32'(err_cnt), 32'd0);
        chk("t5_max_clr", 32'(err_max), 32'd0);

        // saturation
        force_en  = 1'b1;
        keep_data = 1'b1;
        req_data[0 +: IN_W] = bnd(31, 31, 1);
        cnt[0] = 65540;
        req_valid = 4'b0001;
        wait_idle(70000);
        chk("t6_cnt_sat", 32'(err_cnt), 32'h0000FFFF);
        chk("t6_max", 32'(err_max), 32'd3);
        force_en  = 1'b0;
        keep_data = 1'b0;
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
